// File: rtl/vga_sprite_compositor_if.sv
// Pixel, slot-descriptor, tile-ROM and composited-output signals of the sprite compositor.
// master = game-state / timing side, slave = the compositor.
interface vga_sprite_compositor_if #(
  parameter int N_SLOTS = 10,
  parameter int X_W     = 10,
  parameter int Y_W     = 9,
  parameter int ADDR_W  = 10
);
  logic                         pix_valid;
  logic [X_W-1:0]               pix_x;
  logic [Y_W-1:0]               pix_y;
  logic                         frame_start;
  logic [N_SLOTS-1:0]           slot_en;
  logic [N_SLOTS-1:0][1:0]      slot_class;
  logic [N_SLOTS-1:0][X_W-1:0]  slot_x;
  logic [N_SLOTS-1:0][Y_W-1:0]  slot_y;
  logic [N_SLOTS-1:0][2:0]      slot_w;
  logic [N_SLOTS-1:0][3:0]      slot_h;
  logic [ADDR_W-1:0]            tile_addr;
  logic [1:0]                   tile_class;
  logic [11:0]                  tile_data;
  logic [11:0]                  bg_rgb;
  logic                         flash_trigger;
  logic [11:0]                  rgb_out;
  logic                         rgb_valid;
  logic [3:0]                   hit_slot;
  logic                         hit_any;

  modport master (
    output pix_valid, pix_x, pix_y, frame_start,
    output slot_en, slot_class, slot_x, slot_y, slot_w, slot_h,
    output tile_data, bg_rgb, flash_trigger,
    input  tile_addr, tile_class, rgb_out, rgb_valid, hit_slot, hit_any
  );

  modport slave (
    input  pix_valid, pix_x, pix_y, frame_start,
    input  slot_en, slot_class, slot_x, slot_y, slot_w, slot_h,
    input  tile_data, bg_rgb, flash_trigger,
    output tile_addr, tile_class, rgb_out, rgb_valid, hit_slot, hit_any
  );
endinterface

// File: rtl/vga_sprite_compositor.sv
// 3-cycle sprite compositor: slot hit decode -> tile ROM address -> colour-key merge over background.
// Optional damage flash enabled by defining VGA_SPRITE_FLASH_EN.
module vga_sprite_compositor #(
  parameter int          N_SLOTS      = 10,
  parameter int          UNIT_SIZE    = 30,
  parameter int          X_W          = 10,
  parameter int          Y_W          = 9,
  parameter int          ADDR_W       = 10,
  parameter logic [11:0] KEY_COLOR    = 12'hF0F,
  parameter int          FLASH_FRAMES = 32
) (
  input logic                     clk,
  input logic                     rst,
  vga_sprite_compositor_if.slave  bus
);
  localparam int XB = X_W + 5;
  localparam int YB = Y_W + 5;
  localparam logic [X_W-1:0] UX = X_W'(UNIT_SIZE);
  localparam logic [Y_W-1:0] UY = Y_W'(UNIT_SIZE);

  // Shadow descriptor set, latched only on frame_start
  logic [N_SLOTS-1:0]          en_q;
  logic [N_SLOTS-1:0][1:0]     cls_q;
  logic [N_SLOTS-1:0][X_W-1:0] x_q;
  logic [N_SLOTS-1:0][Y_W-1:0] y_q;
  logic [N_SLOTS-1:0][2:0]     w_q;
  logic [N_SLOTS-1:0][3:0]     h_q;

  logic [N_SLOTS-1:0]          en_e;
  logic [N_SLOTS-1:0][1:0]     cls_e;
  logic [N_SLOTS-1:0][X_W-1:0] x_e;
  logic [N_SLOTS-1:0][Y_W-1:0] y_e;
  logic [N_SLOTS-1:0][2:0]     w_e;
  logic [N_SLOTS-1:0][3:0]     h_e;

  // A pixel coinciding with frame_start already sees the incoming set.
  always_comb begin
    en_e  = bus.frame_start ? bus.slot_en    : en_q;
    cls_e = bus.frame_start ? bus.slot_class : cls_q;
    x_e   = bus.frame_start ? bus.slot_x     : x_q;
    y_e   = bus.frame_start ? bus.slot_y     : y_q;
    w_e   = bus.frame_start ? bus.slot_w     : w_q;
    h_e   = bus.frame_start ? bus.slot_h     : h_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q  <= '0;
      cls_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
      w_q   <= '0;
      h_q   <= '0;
    end else if (bus.frame_start) begin
      en_q  <= bus.slot_en;
      cls_q <= bus.slot_class;
      x_q   <= bus.slot_x;
      y_q   <= bus.slot_y;
      w_q   <= bus.slot_w;
      h_q   <= bus.slot_h;
    end
  end

  logic [XB-1:0]      px_ext;
  logic [YB-1:0]      py_ext;
  logic [N_SLOTS-1:0] hit_vec;

  assign px_ext = XB'(bus.pix_x);
  assign py_ext = YB'(bus.pix_y);

  // Widened bounds: sprites running off the right/bottom edge clip instead of wrapping.
  for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_hit
    logic [XB-1:0] x_lo, x_hi;
    logic [YB-1:0] y_lo, y_hi;
    assign x_lo = XB'(x_e[gi]);
    assign x_hi = x_lo + XB'(w_e[gi]) * XB'(UNIT_SIZE);
    assign y_lo = YB'(y_e[gi]);
    assign y_hi = y_lo + YB'(h_e[gi]) * YB'(UNIT_SIZE);
    assign hit_vec[gi] = bus.pix_valid && en_e[gi] &&
                         (px_ext >= x_lo) && (px_ext < x_hi) &&
                         (py_ext >= y_lo) && (py_ext < y_hi);
  end

  logic           win_hit;
  logic [3:0]     win_idx;
  logic [1:0]     win_cls;
  logic [X_W-1:0] win_x, rel_x, mod_x;
  logic [Y_W-1:0] win_y, rel_y, mod_y;
  logic [ADDR_W-1:0] addr_d;

  always_comb begin
    win_hit = 1'b0;
    win_idx = '0;
    win_cls = '0;
    win_x   = '0;
    win_y   = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        win_hit = 1'b1;
        win_idx = 4'(i);
        win_cls = cls_e[i];
        win_x   = x_e[i];
        win_y   = y_e[i];
      end
    end
    rel_x  = bus.pix_x - win_x;
    rel_y  = bus.pix_y - win_y;
    mod_x  = rel_x % UX;
    mod_y  = rel_y % UY;
    addr_d = win_hit ? (ADDR_W'(mod_x) + ADDR_W'(mod_y) * ADDR_W'(UNIT_SIZE)) : '0;
  end

  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        cls1_q;
  logic              v1_q, hit1_q, v2_q, hit2_q;
  logic [3:0]        slot1_q, slot2_q;
  logic [11:0]       rgb_q, rgb_d, sprite_rgb;
  logic              rgb_valid_q, hit_any_q, opaque;
  logic [3:0]        hit_slot_q;

`ifdef VGA_SPRITE_FLASH_EN
  localparam int FC_W = (FLASH_FRAMES < 4) ? 3 : $clog2(FLASH_FRAMES + 1);
  logic [FC_W-1:0] flash_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)
      flash_cnt_q <= '0;
    else if (bus.flash_trigger)
      flash_cnt_q <= FC_W'(FLASH_FRAMES);
    else if (bus.frame_start && (flash_cnt_q != '0))
      flash_cnt_q <= flash_cnt_q - 1'b1;
  end

  assign sprite_rgb = ((flash_cnt_q != '0) && flash_cnt_q[2]) ? 12'hF00 : bus.tile_data;
`else
  logic unused_flash;
  assign unused_flash = bus.flash_trigger;
  assign sprite_rgb   = bus.tile_data;
`endif

  // A keyed winner shows background; lower-priority slots are never consulted.
  assign opaque = hit2_q && (bus.tile_data != KEY_COLOR);
  assign rgb_d  = !v2_q ? 12'h000 : (opaque ? sprite_rgb : bus.bg_rgb);

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      cls1_q      <= '0;
      v1_q        <= 1'b0;
      hit1_q      <= 1'b0;
      slot1_q     <= '0;
      v2_q        <= 1'b0;
      hit2_q      <= 1'b0;
      slot2_q     <= '0;
      rgb_q       <= '0;
      rgb_valid_q <= 1'b0;
      hit_any_q   <= 1'b0;
      hit_slot_q  <= '0;
    end else begin
      addr_q      <= addr_d;
      cls1_q      <= win_hit ? win_cls : 2'b00;
      v1_q        <= bus.pix_valid;
      hit1_q      <= win_hit;
      slot1_q     <= win_idx;
      v2_q        <= v1_q;
      hit2_q      <= hit1_q;
      slot2_q     <= slot1_q;
      rgb_q       <= rgb_d;
      rgb_valid_q <= v2_q;
      hit_any_q   <= v2_q && opaque;
      hit_slot_q  <= v2_q ? slot2_q : 4'd0;
    end
  end

  assign bus.tile_addr  = addr_q;
  assign bus.tile_class = cls1_q;
  assign bus.rgb_out    = rgb_q;
  assign bus.rgb_valid  = rgb_valid_q;
  assign bus.hit_any    = hit_any_q;
  assign bus.hit_slot   = hit_slot_q;
endmodule

// File: tb/tb_vga_sprite_compositor.sv
// Bench for vga_sprite_compositor: vector table plus hand sequences, scoreboard queues keyed by due cycle.
// Tile ROM model returns {tile_class, tile_addr} one cycle after the address, or the colour key on request.
module tb_vga_sprite_compositor;
  localparam logic [11:0] KEY = 12'hF0F;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_sprite_compositor_if #(.N_SLOTS(10), .X_W(10), .Y_W(9), .ADDR_W(10)) bus ();

  vga_sprite_compositor #(
    .N_SLOTS(10), .UNIT_SIZE(30), .X_W(10), .Y_W(9), .ADDR_W(10),
    .KEY_COLOR(12'hF0F), .FLASH_FRAMES(32)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        key_now = 1'b0, key_d1 = 1'b0;
  logic [11:0] bg_now = '0, bg_d1 = '0;
  always @(posedge clk) begin
    key_d1        <= key_now;
    bg_d1         <= bg_now;
    bus.bg_rgb    <= bg_d1;
    bus.tile_data <= key_d1 ? KEY : {bus.tile_class, bus.tile_addr};
  end

  typedef struct {
    int          due;
    logic [9:0]  addr;
    logic [1:0]  cls;
    string       name;
  } addr_exp_t;

  typedef struct {
    int          due;
    logic        valid;
    logic [11:0] rgb;
    logic [3:0]  slot;
    logic        hit;
    string       name;
  } out_exp_t;

  typedef struct {
    int   x, y;
    logic pv, key;
    logic [11:0] bg;
    logic hit;
    int   slot, addr, cls;
  } vec_t;

  addr_exp_t aq[$];
  out_exp_t  oq[$];
  addr_exp_t ae;
  out_exp_t  oe;
  int checks = 0;
  int errors = 0;
  int model_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    while (aq.size() > 0 && aq[0].due <= cyc) begin
      ae = aq.pop_front();
      if (ae.due < cyc) chk({ae.name, ":addr_missed"}, 32'(cyc), 32'(ae.due));
      else begin
        chk({ae.name, ":tile_addr"}, 32'(bus.tile_addr), 32'(ae.addr));
        chk({ae.name, ":tile_class"}, 32'(bus.tile_class), 32'(ae.cls));
      end
    end
    while (oq.size() > 0 && oq[0].due <= cyc) begin
      oe = oq.pop_front();
      if (oe.due < cyc) chk({oe.name, ":out_missed"}, 32'(cyc), 32'(oe.due));
      else begin
        chk({oe.name, ":rgb_valid"}, 32'(bus.rgb_valid), 32'(oe.valid));
        chk({oe.name, ":rgb_out"}, 32'(bus.rgb_out), 32'(oe.rgb));
        chk({oe.name, ":hit_slot"}, 32'(bus.hit_slot), 32'(oe.slot));
        chk({oe.name, ":hit_any"}, 32'(bus.hit_any), 32'(oe.hit));
        $display("pixel %s rgb_valid=%0d rgb_out=%03h hit_slot=%0d hit_any=%0d",
                 oe.name, bus.rgb_valid, bus.rgb_out, bus.hit_slot, bus.hit_any);
      end
    end
  end

  task automatic set_slot(input int i, input logic en, input int cls, x, y, w, h);
    bus.slot_en[i]    = en;
    bus.slot_class[i] = 2'(cls);
    bus.slot_x[i]     = 10'(x);
    bus.slot_y[i]     = 9'(y);
    bus.slot_w[i]     = 3'(w);
    bus.slot_h[i]     = 4'(h);
  endtask

  // One pixel cycle; expectations are pushed for t+1 (address) and t+3 (colour).
  task automatic drive(input int px, py, input logic pv, fs, trig, key, input logic [11:0] bg,
                       input logic e_hit, input int e_slot, e_addr, e_cls,
                       input logic push, input string nm);
    addr_exp_t a;
    out_exp_t  o;
    logic      flash_on;
    @(posedge clk);
    #1;
    bus.pix_x         = 10'(px);
    bus.pix_y         = 9'(py);
    bus.pix_valid     = pv;
    bus.frame_start   = fs;
    bus.flash_trigger = trig;
    key_now           = key;
    bg_now            = bg;
    if (trig) model_cnt = 32;
    else if (fs && model_cnt != 0) model_cnt--;
`ifdef VGA_SPRITE_FLASH_EN
    flash_on = (model_cnt != 0) && (model_cnt[2] == 1'b1);
`else
    flash_on = 1'b0;
`endif
    if (push) begin
      a.due  = cyc + 1;
      a.addr = (pv && e_hit) ? 10'(e_addr) : 10'd0;
      a.cls  = (pv && e_hit) ? 2'(e_cls) : 2'd0;
      a.name = nm;
      aq.push_back(a);
      o.due   = cyc + 3;
      o.name  = nm;
      o.valid = pv;
      if (!pv) begin
        o.rgb = '0; o.slot = '0; o.hit = 1'b0;
      end else if (e_hit && !key) begin
        o.rgb  = flash_on ? 12'hF00 : {2'(e_cls), 10'(e_addr)};
        o.slot = 4'(e_slot); o.hit = 1'b1;
      end else if (e_hit) begin
        o.rgb = bg; o.slot = 4'(e_slot); o.hit = 1'b0;
      end else begin
        o.rgb = bg; o.slot = '0; o.hit = 1'b0;
      end
      oq.push_back(o);
    end
  endtask

  task automatic drain(input string nm);
    @(posedge clk);
    #1;
    bus.pix_valid     = 1'b0;
    bus.frame_start   = 1'b0;
    bus.flash_trigger = 1'b0;
    key_now           = 1'b0;
    for (int k = 0; k < 20 && (aq.size() > 0 || oq.size() > 0); k++) @(posedge clk);
    @(negedge clk);
    if (aq.size() > 0 || oq.size() > 0) begin
      chk({nm, ":drain_timeout"}, 32'(aq.size() + oq.size()), 32'd0);
      aq.delete();
      oq.delete();
    end
  endtask

  function automatic vec_t mk(input int x, y, input logic pv, key, input logic [11:0] bg,
                              input logic hit, input int slot, addr, cls);
    vec_t v;
    v.x = x; v.y = y; v.pv = pv; v.key = key; v.bg = bg;
    v.hit = hit; v.slot = slot; v.addr = addr; v.cls = cls;
    return v;
  endfunction

  vec_t vt[16];

  initial begin
    vt[0]  = mk(175, 210, 1, 0, 12'h111, 1, 0, 315, 1);
    vt[1]  = mk(159, 210, 1, 0, 12'h222, 0, 0, 0, 0);
    vt[2]  = mk(190, 210, 1, 0, 12'h333, 0, 0, 0, 0);
    vt[3]  = mk(189, 229, 1, 0, 12'h444, 1, 0, 899, 1);
    vt[4]  = mk(160, 200, 1, 0, 12'h555, 1, 0, 0, 1);
    vt[5]  = mk(305, 105, 1, 0, 12'h666, 1, 2, 155, 2);
    vt[6]  = mk(305, 105, 1, 1, 12'h777, 1, 2, 155, 2);
    vt[7]  = mk(345, 135, 1, 0, 12'h888, 1, 2, 165, 2);
    vt[8]  = mk(639, 300, 1, 0, 12'h999, 1, 1, 19, 0);
    vt[9]  = mk(0,   300, 1, 0, 12'hAAA, 0, 0, 0, 0);
    vt[10] = mk(620, 329, 1, 0, 12'hBBB, 1, 1, 870, 0);
    vt[11] = mk(410, 405, 1, 0, 12'hCCC, 0, 0, 0, 0);
    vt[12] = mk(455, 400, 1, 0, 12'hDDD, 0, 0, 0, 0);
    vt[13] = mk(359, 159, 1, 0, 12'hEEE, 1, 2, 899, 2);
    vt[14] = mk(360, 159, 1, 0, 12'h123, 0, 0, 0, 0);
    vt[15] = mk(175, 210, 0, 0, 12'h456, 1, 0, 315, 1);

    bus.pix_valid = 1'b0; bus.pix_x = '0; bus.pix_y = '0;
    bus.frame_start = 1'b0; bus.flash_trigger = 1'b0;
    bus.slot_en = '0; bus.slot_class = '0; bus.slot_x = '0;
    bus.slot_y = '0; bus.slot_w = '0; bus.slot_h = '0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset:rgb_valid", 32'(bus.rgb_valid), 32'd0);
    chk("reset:rgb_out", 32'(bus.rgb_out), 32'd0);
    chk("reset:tile_addr", 32'(bus.tile_addr), 32'd0);
    chk("reset:tile_class", 32'(bus.tile_class), 32'd0);
    chk("reset:hit_any", 32'(bus.hit_any), 32'd0);
    chk("reset:hit_slot", 32'(bus.hit_slot), 32'd0);
    rst = 1'b0;

    // Descriptors presented but never latched: no sprite may appear yet.
    set_slot(0, 1'b1, 1, 100, 100, 1, 1);
    drive(110, 110, 1, 0, 0, 0, 12'h0A5, 0, 0, 0, 0, 1, "pre_fs_a");
    drive(100, 100, 1, 0, 0, 0, 12'h05A, 0, 0, 0, 0, 1, "pre_fs_b");

    set_slot(0, 1'b1, 1, 160, 200, 1, 1);
    set_slot(1, 1'b1, 0, 620, 300, 2, 1);
    set_slot(2, 1'b1, 2, 300, 100, 2, 2);
    set_slot(3, 1'b1, 1, 400, 400, 0, 1);
    set_slot(4, 1'b1, 1, 450, 400, 1, 0);
    set_slot(5, 1'b1, 0, 300, 100, 1, 1);
    drive(0, 0, 0, 1, 0, 0, 12'h000, 0, 0, 0, 0, 1, "frame1");
    for (int i = 0; i < 16; i++)
      drive(vt[i].x, vt[i].y, vt[i].pv, 0, 0, vt[i].key, vt[i].bg,
            vt[i].hit, vt[i].slot, vt[i].addr, vt[i].cls, 1, $sformatf("vec%0d", i));

    // Mid-frame descriptor change must wait for the next frame_start.
    set_slot(0, 1'b1, 1, 400, 200, 1, 1);
    drive(175, 210, 1, 0, 0, 0, 12'h321, 1, 0, 315, 1, 1, "mid_old");
    drive(175, 210, 1, 1, 0, 0, 12'h654, 0, 0, 0, 0, 1, "fs_same_cycle");
    drive(405, 210, 1, 0, 0, 0, 12'h987, 1, 0, 305, 1, 1, "after_fs");
    drain("seq_shadow");

`ifdef VGA_SPRITE_FLASH_EN
    drive(0, 0, 0, 0, 1, 0, 12'h000, 0, 0, 0, 0, 1, "trig");
    for (int f = 0; f < 36; f++) begin
      drive(0, 0, 0, 1, 0, 0, 12'h000, 0, 0, 0, 0, 1, $sformatf("fl_fs%0d", f));
      drive(405, 210, 1, 0, 0, 0, 12'h0F0, 1, 0, 305, 1, 1, $sformatf("fl_px%0d", f));
      repeat (3) drive(0, 0, 0, 0, 0, 0, 12'h000, 0, 0, 0, 0, 1, "fl_idle");
    end
    drive(0, 0, 0, 0, 1, 0, 12'h000, 0, 0, 0, 0, 1, "retrig");
    for (int f = 0; f < 4; f++) begin
      drive(0, 0, 0, 1, 0, 0, 12'h000, 0, 0, 0, 0, 1, "rt_fs");
      repeat (3) drive(0, 0, 0, 0, 0, 0, 12'h000, 0, 0, 0, 0, 1, "rt_idle");
    end
    drive(405, 210, 1, 0, 0, 0, 12'h0F0, 1, 0, 305, 1, 1, "rt_px");
    drain("seq_flash");
`endif

    // Reset mid-frame: the in-flight pixel must never surface.
    drive(405, 210, 1, 0, 0, 0, 12'h0F0, 1, 0, 305, 1, 0, "rst_px");
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.pix_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid:rgb_valid_t2", 32'(bus.rgb_valid), 32'd0);
    @(negedge clk);
    chk("rst_mid:rgb_valid_t3", 32'(bus.rgb_valid), 32'd0);
    chk("rst_mid:hit_any", 32'(bus.hit_any), 32'd0);
    rst = 1'b0;
    model_cnt = 0;
    drive(405, 210, 1, 0, 0, 0, 12'h246, 0, 0, 0, 0, 1, "post_rst_nofs");
    drive(0, 0, 0, 1, 0, 0, 12'h000, 0, 0, 0, 0, 1, "post_rst_fs");
    drive(405, 210, 1, 0, 0, 0, 12'h135, 1, 0, 305, 1, 1, "post_rst_px");
    drain("seq_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_sprite_compositor.md
Name: vga_sprite_compositor

Overview:
- Pipelined, parametrised successor of the VGA pixel/state compositor.
- Resolves which of N_SLOTS sprite slots covers the current pixel and issues the tile ROM address. Merges the returned tile data over a caller-supplied background with colour-key transparency.
- Slot descriptors are double-buffered at frame start, so game logic can update mid-frame without tearing.
- Sits between the game-state logic and the VGA timing/output stage.

Parameters:
N_SLOTS, 10, number of sprite slots; slot 0 has highest priority
UNIT_SIZE, 30, tile edge in pixels; sprites are w x h tiles
X_W, 10, pixel x width
Y_W, 9, pixel y width
ADDR_W, 10, tile ROM address width (must hold UNIT_SIZE*UNIT_SIZE-1)
KEY_COLOR, 12'hF0F, transparent colour key
FLASH_FRAMES, 32, flash duration in frames (optional feature only)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
pix_valid  in  1  pix_x/pix_y valid this cycle (visible area)
pix_x  in  X_W  current pixel x
pix_y  in  Y_W  current pixel y
frame_start  in  1  one-cycle pulse before first pixel of a frame
slot_en  in  N_SLOTS  per-slot enable
slot_class  in  N_SLOTS x 2  tile sheet select per slot
slot_x  in  N_SLOTS x X_W  slot left edge
slot_y  in  N_SLOTS x Y_W  slot top edge
slot_w  in  N_SLOTS x 3  width in tiles
slot_h  in  N_SLOTS x 4  height in tiles
tile_addr  out  ADDR_W  tile ROM address (registered)
tile_class  out  2  tile sheet select, aligned with tile_addr
tile_data  in  12  ROM data; returned exactly 1 cycle after tile_addr
bg_rgb  in  12  background for the pixel; caller aligns it with tile_data
flash_trigger  in  1  start damage flash (optional feature)
rgb_out  out  12  composited pixel
rgb_valid  out  1  rgb_out valid
hit_slot  out  4  winning slot index, aligned with rgb_out
hit_any  out  1  an opaque sprite pixel won, aligned with rgb_out

Behaviour:
- Shadow registers:
  - Active descriptor set updates from the slot_* inputs only on the cycle frame_start=1.
  - If frame_start and pix_valid are high together, that pixel already uses the new set.
- Pipeline, for a pixel presented at cycle t:
  - t+1: hit decode registered. tile_addr = (rel_x mod UNIT_SIZE) + (rel_y mod UNIT_SIZE)*UNIT_SIZE; tile_class = winning slot's class.
  - t+2: tile_data and bg_rgb sampled.
  - t+3: rgb_out, rgb_valid, hit_slot and hit_any registered. Fixed latency 3 cycles; no stalls.
- Hit rule: slot i hits when slot_en[i] and slot_x ≤ pix_x < slot_x + w*UNIT_SIZE and slot_y ≤ pix_y < slot_y + h*UNIT_SIZE.
  - Bound arithmetic is done X_W+5 / Y_W+5 bits wide, so there is no wrap; sprites extending past 639/479 are clipped naturally.
  - w=0 or h=0 never hits.
- Priority and transparency:
  - The lowest hitting index wins.
  - If the winner's tile_data == KEY_COLOR, rgb_out = bg_rgb and hit_any = 0. Lower-priority slots are not consulted.
  - No hit: rgb_out = bg_rgb, hit_any = 0, hit_slot = 0, tile_addr = 0.
- pix_valid=0 propagates: rgb_valid=0, rgb_out=0, hit_any=0 at t+3.
- Reset:
  - All outputs 0.
  - Shadow slot_en cleared, so no sprites show until the first frame_start.
  - Pipeline valid bits cleared; a mid-frame rst gives rgb_valid=0 from the next cycle.

Optional Feature:
- Macro VGA_SPRITE_FLASH_EN.
- Defined:
  - flash_trigger loads a frame counter with FLASH_FRAMES; it decrements on each frame_start and stops at 0.
  - While counter ≠ 0 and counter[2]=1, opaque winning sprite pixels output 12'hF00 instead of tile_data.
  - A retrigger while active reloads the counter.
  - rst clears the counter.
- Undefined: flash_trigger is ignored, no counter is built, rgb path is unchanged.

Test Plan:
- rst, then pixels with no frame_start and slot 0 enabled at (100,100) -> rgb_out = bg_rgb, hit_any=0, until frame_start.
- Slot 0 at (160,200), w=1, h=1; frame_start; pixel (175,210) -> tile_addr=315 at t+1, rgb_out=tile_data at t+3, hit_slot=0, hit_any=1.
- Slots 2 and 5 overlapping at (300,100) -> hit_slot=2; force tile_data=12'hF0F -> rgb_out=bg_rgb, hit_any=0.
- Slot 1 x=620, w=2; pixel (639,y) hits; pixel x=0 same row does not hit (no wrap); w=0 never hits.
- Change slot_x mid-frame -> output unchanged until the next frame_start; frame_start with pix_valid in the same cycle uses the new value.
- VGA_SPRITE_FLASH_EN: trigger, count frames -> sprite pixels 12'hF00 during frames where counter[2]=1, normal after 32 frames; rst mid-flash clears it immediately.
